// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, drives the combinational instruction ROM and
// buffers {pc, inst} pairs in a small queue popped by decode. Optional macro: IF_ALIGN_CHECK_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ce,
  output logic [31:0] addr,
  input  logic [31:0] inst_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FQ_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
`ifdef IF_ALIGN_CHECK_EN
  localparam logic [1:0] HALT = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [31:0]      fq_pc_q   [FQ_DEPTH];
  logic [31:0]      fq_pc_d   [FQ_DEPTH];
  logic [31:0]      fq_inst_q [FQ_DEPTH];
  logic [31:0]      fq_inst_d [FQ_DEPTH];
`ifdef IF_ALIGN_CHECK_EN
  logic             misalign_q, misalign_d;
`endif

  logic        redirect;
  logic [31:0] target;
  logic        push;
  logic        pop;

  // Decode handshake: an entry transfers on a rising edge where id_valid_o and
  // id_ready_i are both high; id_valid_o never depends on id_ready_i, and a
  // redirect in the same cycle cancels the transfer.
  always_comb begin
    redirect = flush_i | branch_flag_i;
    target   = flush_i ? new_pc_i : branch_target_i;
    push     = (state_q == RUN) && (count_q != FULL_CNT) && !redirect;
    pop      = (count_q != '0) && id_ready_i && !redirect;

    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    head_d    = head_q;
    tail_d    = tail_q;
    fq_pc_d   = fq_pc_q;
    fq_inst_d = fq_inst_q;
`ifdef IF_ALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif

    if (redirect) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
`ifdef IF_ALIGN_CHECK_EN
      pc_d = target;
      if (target[1:0] != 2'b00) begin
        state_d    = HALT;
        misalign_d = 1'b1;
      end else begin
        state_d    = RUN;
        misalign_d = 1'b0;
      end
`else
      pc_d    = target & 32'hFFFF_FFFC;
      state_d = RUN;
`endif
    end else begin
      if (state_q == IDLE) begin
        state_d = RUN;
      end
      if (push) begin
        fq_pc_d[tail_q]   = pc_q;
        fq_inst_d[tail_q] = inst_i;
        tail_d            = tail_q + PTR_W'(1);
        pc_d              = pc_q + 32'd4;
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
`ifdef IF_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
`ifdef IF_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Queue storage needs no reset: entries are only observed below the count.
  always_ff @(posedge clk) begin
    fq_pc_q   <= fq_pc_d;
    fq_inst_q <= fq_inst_d;
  end

  always_comb begin
    ce         = push;
    addr       = push ? pc_q : 32'h0000_0000;
    id_valid_o = (count_q != '0);
    id_pc_o    = id_valid_o ? fq_pc_q[head_q]   : 32'h0000_0000;
    id_inst_o  = id_valid_o ? fq_inst_q[head_q] : 32'h0000_0000;
  end

`ifdef IF_ALIGN_CHECK_EN
  assign misalign_o = misalign_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table followed by randomized traffic
// checked every cycle against a queue-based reference model.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FQ       = 4;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        id_ready_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
`ifdef IF_ALIGN_CHECK_EN
  logic        misalign_o;
`endif

  inst_fetch #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ)) dut (
    .clk             (clk),
    .rst             (rst),
    .ce              (ce),
    .addr            (addr),
    .inst_i          (inst_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .id_ready_i      (id_ready_i),
    .id_valid_o      (id_valid_o),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o)
`ifdef IF_ALIGN_CHECK_EN
    ,
    .misalign_o      (misalign_o)
`endif
  );

  // ROM: word i holds i
  assign inst_i = addr >> 2;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        br;
    logic [31:0] tgt;
    logic        fl;
    logic [31:0] npc;
    logic        rdy;
    logic        e_ce;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  vec_t tbl[$];
  int   n_checks;
  int   n_err;
  int   cyc;

  // reference model
  logic [31:0] m_pc;
  logic [31:0] exp_q[$];
  bit          m_started;
  bit          m_halted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic add_v(input logic r, input logic br, input logic [31:0] tgt,
                       input logic fl, input logic [31:0] npc, input logic rdy,
                       input logic e_ce, input logic [31:0] e_addr, input logic e_v,
                       input logic [31:0] e_pc, input logic e_mis);
    vec_t v;
    v.rst = r; v.br = br; v.tgt = tgt; v.fl = fl; v.npc = npc; v.rdy = rdy;
    v.e_ce = e_ce; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc; v.e_mis = e_mis;
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    m_pc = RESET_PC;
    exp_q.delete();
    m_started = 0;
    m_halted  = 0;
  endtask

  task automatic model_edge();
    logic [31:0] t;
    bit          fetch;
    if (!rst) begin
      model_reset();
    end else if (flush_i || branch_flag_i) begin
      t = flush_i ? new_pc_i : branch_target_i;
      exp_q.delete();
      m_started = 1;
`ifdef IF_ALIGN_CHECK_EN
      m_pc     = t;
      m_halted = (t % 4) != 0;
`else
      m_pc     = t - (t % 4);
      m_halted = 0;
`endif
    end else begin
      fetch = m_started && !m_halted && (exp_q.size() < FQ);
      if (exp_q.size() != 0 && id_ready_i) void'(exp_q.pop_front());
      if (fetch) begin
        exp_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
      m_started = 1;
    end
  endtask

  task automatic cycle(input bit use_tbl, input vec_t v);
    bit          m_ce;
    bit          m_v;
    logic [31:0] m_hpc;
    @(negedge clk);
    m_ce  = m_started && !m_halted && (exp_q.size() < FQ) && !(flush_i || branch_flag_i);
    m_v   = exp_q.size() != 0;
    m_hpc = m_v ? exp_q[0] : 32'h0;
    chk("ce", {31'd0, ce}, {31'd0, m_ce});
    chk("addr", addr, m_ce ? m_pc : 32'h0);
    chk("id_valid", {31'd0, id_valid_o}, {31'd0, m_v});
    chk("id_pc", id_pc_o, m_hpc);
    chk("id_inst", id_inst_o, m_hpc >> 2);
`ifdef IF_ALIGN_CHECK_EN
    chk("misalign", {31'd0, misalign_o}, {31'd0, m_halted});
`endif
    if (use_tbl) begin
      chk("tbl_ce", {31'd0, ce}, {31'd0, v.e_ce});
      chk("tbl_addr", addr, v.e_addr);
      chk("tbl_valid", {31'd0, id_valid_o}, {31'd0, v.e_v});
      chk("tbl_pc", id_pc_o, v.e_pc);
      chk("tbl_inst", id_inst_o, v.e_v ? (v.e_pc >> 2) : 32'h0);
`ifdef IF_ALIGN_CHECK_EN
      chk("tbl_misalign", {31'd0, misalign_o}, {31'd0, v.e_mis});
`endif
    end
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic fill_table();
    // reset, then one instruction per cycle with ready high
    add_v(0, 0, 0, 0, 0, 1,  0, 32'h0,  0, 32'h0,  0);
    add_v(0, 0, 0, 0, 0, 1,  0, 32'h0,  0, 32'h0,  0);
    add_v(1, 0, 0, 0, 0, 1,  0, 32'h0,  0, 32'h0,  0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h0,  0, 32'h0,  0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h4,  1, 32'h0,  0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h8,  1, 32'h4,  0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'hC,  1, 32'h8,  0);
    // reset mid-run: outputs still reflect state until the edge
    add_v(0, 0, 0, 0, 0, 0,  1, 32'h10, 1, 32'hC,  0);
    add_v(0, 0, 0, 0, 0, 0,  0, 32'h0,  0, 32'h0,  0);
    // ready low from release: four pushes then full
    add_v(1, 0, 0, 0, 0, 0,  0, 32'h0,  0, 32'h0,  0);
    add_v(1, 0, 0, 0, 0, 0,  1, 32'h0,  0, 32'h0,  0);
    add_v(1, 0, 0, 0, 0, 0,  1, 32'h4,  1, 32'h0,  0);
    add_v(1, 0, 0, 0, 0, 0,  1, 32'h8,  1, 32'h0,  0);
    add_v(1, 0, 0, 0, 0, 0,  1, 32'hC,  1, 32'h0,  0);
    add_v(1, 0, 0, 0, 0, 0,  0, 32'h0,  1, 32'h0,  0);
    add_v(1, 0, 0, 0, 0, 0,  0, 32'h0,  1, 32'h0,  0);
    // drain: pop while full does not fetch, then 16 follows without gap
    add_v(1, 0, 0, 0, 0, 1,  0, 32'h0,  1, 32'h0,  0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h10, 1, 32'h4,  0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h14, 1, 32'h8,  0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h18, 1, 32'hC,  0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h1C, 1, 32'h10, 0);
    // branch to 0x40 with three entries queued
    add_v(1, 1, 32'h40, 0, 0, 1,  0, 32'h0,  1, 32'h14, 0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h40, 0, 32'h0,  0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h44, 1, 32'h40, 0);
    // flush beats branch
    add_v(1, 1, 32'h40, 1, 32'h100, 1,  0, 32'h0,   1, 32'h44,  0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h100, 0, 32'h0,   0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h104, 1, 32'h100, 0);
    // PC wrap
    add_v(1, 1, 32'hFFFF_FFF8, 0, 0, 1,  0, 32'h0,         1, 32'h104,       0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'hFFFF_FFF8, 0, 32'h0,         0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h0,         1, 32'hFFFF_FFFC, 0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h4,         1, 32'h0,         0);
    // misaligned branch target
    add_v(1, 1, 32'h42, 0, 0, 1,  0, 32'h0,  1, 32'h4,  0);
`ifdef IF_ALIGN_CHECK_EN
    add_v(1, 0, 0, 0, 0, 1,  0, 32'h0,  0, 32'h0,  1);
    add_v(1, 0, 0, 0, 0, 1,  0, 32'h0,  0, 32'h0,  1);
    add_v(1, 1, 32'h80, 0, 0, 1,  0, 32'h0,  0, 32'h0,  1);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h80, 0, 32'h0,  0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h84, 1, 32'h80, 0);
`else
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h40, 0, 32'h0,  0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h44, 1, 32'h40, 0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h48, 1, 32'h44, 0);
    add_v(1, 0, 0, 0, 0, 1,  1, 32'h4C, 1, 32'h48, 0);
`endif
  endtask

  initial begin
    vec_t dummy;
    n_checks = 0;
    n_err    = 0;
    cyc      = 0;
    rst = 0; branch_flag_i = 0; branch_target_i = 0;
    flush_i = 0; new_pc_i = 0; id_ready_i = 0;
    dummy = '{default: '0};
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    fill_table();
    foreach (tbl[i]) begin
      rst             = tbl[i].rst;
      branch_flag_i   = tbl[i].br;
      branch_target_i = tbl[i].tgt;
      flush_i         = tbl[i].fl;
      new_pc_i        = tbl[i].npc;
      id_ready_i      = tbl[i].rdy;
      cycle(1, tbl[i]);
    end

    for (int n = 0; n < 3000; n++) begin
      int kind;
      rst           = ($urandom_range(0, 199) != 0);
      branch_flag_i = ($urandom_range(0, 19) == 0);
      flush_i       = ($urandom_range(0, 29) == 0);
      id_ready_i    = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 7);
      case (kind)
        0:       branch_target_i = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
        1:       branch_target_i = $urandom;
        default: branch_target_i = 32'($urandom_range(0, 255)) * 4;
      endcase
      kind = $urandom_range(0, 7);
      new_pc_i = (kind == 0) ? $urandom : 32'($urandom_range(0, 255)) * 4;
      cycle(0, dummy);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
